// File: rtl/multicycle_sequencer.sv
// Control sequencer for a multicycle RISC-V style datapath: fetch/decode/execute FSM,
// PC register, memory wait-timeout guard and retired-instruction counter.
module multicycle_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'd9600,
  parameter int              MAX_WAIT     = 15,
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instr,
  input  logic             Zero,
  input  logic [XLEN-1:0]  ResultWire,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic [XLEN-1:0]  PC,
  output logic             PCWrite,
  output logic             AddrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             fault,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       fsm_state
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_FAULT    = 4'd11
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout;
  logic              retire;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              unused_instr;

  assign opcode       = Instr[6:0];
  assign funct3       = Instr[14:12];
  assign unused_instr = ^{Instr[31], Instr[29:15], Instr[11:7]};
  assign timeout      = (wait_cnt == WAIT_LIMIT);
  assign fsm_state    = state;
  assign fault        = !reset && (state == S_FAULT);

  // Memory handshake: mem_req stays high while a memory state waits; the
  // access completes on the cycle where mem_req && mem_ready, unless the
  // wait counter has already hit its limit, in which case no enable fires.
  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    AddrSrc    = 1'b0;
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ImmSrc     = 2'b00;
    ALUControl = 3'b000;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (timeout) begin
          next_state = S_FAULT;
        end else if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b10;
        case (opcode)
          7'b0000011, 7'b0100011: next_state = S_MEMADR;
          7'b0110011:             next_state = S_EXECR;
          7'b0010011:             next_state = S_EXECI;
          7'b1100011:             next_state = S_BEQ;
          7'b1101111:             next_state = S_JAL;
          default:                next_state = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ImmSrc     = Instr[5] ? 2'b01 : 2'b00;
        next_state = Instr[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AddrSrc = 1'b1;
        if (timeout)        next_state = S_FAULT;
        else if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        AddrSrc = 1'b1;
        if (timeout) begin
          next_state = S_FAULT;
        end else if (mem_ready) begin
          MemWrite   = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        ResultSrc  = 2'b01;
        next_state = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = (state == S_EXECI) ? 2'b01 : 2'b00;
        next_state = S_ALUWB;
        // funct7[5] selects sub only for register-register ops; for
        // immediates bit 30 is part of the immediate.
        case (funct3)
          3'b000:  ALUControl = ((state == S_EXECR) && Instr[30]) ? 3'b001 : 3'b000;
          3'b111:  ALUControl = 3'b010;
          3'b110:  ALUControl = 3'b011;
          3'b010:  ALUControl = 3'b101;
          default: next_state = S_FAULT;
        endcase
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        PCWrite    = Zero;
        next_state = S_FETCH;
      end
      S_JAL: begin
        PCWrite    = 1'b1;
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        next_state = S_ALUWB;
      end
      S_FAULT: next_state = S_FAULT;
      default: next_state = S_FAULT;
    endcase
    if (reset) begin
      mem_req  = 1'b0;
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign retire = (next_state == S_FETCH) &&
                  ((state == S_MEMWB) || (state == S_MEMWRITE) ||
                   (state == S_ALUWB) || (state == S_BEQ));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      PC       <= RESET_VECTOR;
      instret  <= '0;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (PCWrite) PC <= ResultWire;
      // Any state change clears the counter, so every memory state starts at zero.
      if (next_state != state)                        wait_cnt <= '0;
      else if (mem_req && !mem_ready && !timeout)     wait_cnt <= wait_cnt + 1'b1;
      if (retire) instret <= instret + 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: one task per scenario with inline checks.
module tb_multicycle_sequencer;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      Instr;
  logic             Zero;
  logic [XLEN-1:0]  ResultWire;
  logic             mem_ready;
  logic             mem_req;
  logic [XLEN-1:0]  PC;
  logic             PCWrite, AddrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0]       ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]       ALUControl;
  logic             fault;
  logic [CNT_W-1:0] instret;
  logic [3:0]       fsm_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_instret;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2,
    ST_MEMREAD = 4'd3, ST_MEMWB = 4'd4, ST_MEMWRITE = 4'd5, ST_EXECR = 4'd6,
    ST_EXECI = 4'd7, ST_ALUWB = 4'd8, ST_BEQ = 4'd9, ST_JAL = 4'd10, ST_FAULT = 4'd11;

  // ALU decode vectors: instruction, expected ALUControl, ALUSrcB, exec state
  logic [31:0] vec_instr [8] = '{32'h002081B3, 32'h402081B3, 32'h0020F1B3, 32'h0020E1B3,
                                 32'h0020A1B3, 32'h0050E093, 32'h0050A093, 32'h40000093};
  logic [2:0]  vec_ctrl  [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b011, 3'b101, 3'b000};
  logic [1:0]  vec_srcb  [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
  logic [3:0]  vec_state [8] = '{ST_EXECR, ST_EXECR, ST_EXECR, ST_EXECR, ST_EXECR,
                                 ST_EXECI, ST_EXECI, ST_EXECI};

  multicycle_sequencer dut (
    .clk(clk), .reset(reset), .Instr(Instr), .Zero(Zero), .ResultWire(ResultWire),
    .mem_ready(mem_ready), .mem_req(mem_req), .PC(PC), .PCWrite(PCWrite),
    .AddrSrc(AddrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .fault(fault), .instret(instret), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    next_cycle();
    reset = 1'b0;
    exp_pc = 32'd9600;
    exp_instret = 32'd0;
  endtask

  // Ready fetch from FETCH; returns one cycle later in DECODE.
  task automatic do_fetch(input logic [31:0] instr, input logic [31:0] new_pc);
    Instr = instr;
    ResultWire = new_pc;
    mem_ready = 1'b1;
    next_cycle();
    exp_pc = new_pc;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; Instr = 32'h0; Zero = 1'b0; ResultWire = 32'h1234;
    next_cycle();
    next_cycle();
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    n_cmp++; if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0) begin n_err++; $display("FAIL rst_enables: got %b want 0000", {PCWrite, IRWrite, RegWrite, MemWrite}); end
    n_cmp++; if (PC !== 32'd9600) begin n_err++; $display("FAIL rst_pc: got %0d want 9600", PC); end
    n_cmp++; if (instret !== 32'd0) begin n_err++; $display("FAIL rst_instret: got %0d want 0", instret); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL rst_fault: got %b want 0", fault); end
    n_cmp++; if (fsm_state !== ST_FETCH) begin n_err++; $display("FAIL rst_state: got %0d want %0d", fsm_state, ST_FETCH); end
    reset = 1'b0;
    exp_pc = 32'd9600;
    exp_instret = 32'd0;
  endtask

  task automatic test_addi();
    Instr = 32'h00500093; ResultWire = 32'd9604; mem_ready = 1'b1;
    #1;
    n_cmp++; if ({mem_req, IRWrite, PCWrite} !== 3'b111) begin n_err++; $display("FAIL addi_fetch: got %b want 111", {mem_req, IRWrite, PCWrite}); end
    n_cmp++; if ({ALUSrcA, ALUSrcB, ResultSrc, AddrSrc} !== 7'b00_10_10_0) begin n_err++; $display("FAIL addi_fetch_mux: got %b want 0010100", {ALUSrcA, ALUSrcB, ResultSrc, AddrSrc}); end
    next_cycle();
    n_cmp++; if (PC !== 32'd9604) begin n_err++; $display("FAIL addi_pc: got %0d want 9604", PC); end
    n_cmp++; if ({ALUSrcA, ALUSrcB, ImmSrc} !== 6'b01_01_10) begin n_err++; $display("FAIL addi_decode: got %b want 010110", {ALUSrcA, ALUSrcB, ImmSrc}); end
    next_cycle();
    n_cmp++; if (fsm_state !== ST_EXECI) begin n_err++; $display("FAIL addi_execi: got %0d want %0d", fsm_state, ST_EXECI); end
    next_cycle();
    n_cmp++; if ({RegWrite, ResultSrc} !== 3'b1_00) begin n_err++; $display("FAIL addi_regwrite_c4: got %b want 100", {RegWrite, ResultSrc}); end
    next_cycle();
    exp_pc = 32'd9604;
    exp_instret = 32'd1;
    n_cmp++; if (instret !== exp_instret) begin n_err++; $display("FAIL addi_instret: got %0d want %0d", instret, exp_instret); end
    n_cmp++; if (fsm_state !== ST_FETCH) begin n_err++; $display("FAIL addi_back_fetch: got %0d want %0d", fsm_state, ST_FETCH); end
  endtask

  task automatic test_fetch_wait();
    Instr = 32'h002081B3; ResultWire = exp_pc + 32'd4; mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({mem_req, IRWrite, PCWrite} !== 3'b100) begin n_err++; $display("FAIL wait_hold[%0d]: got %b want 100", i, {mem_req, IRWrite, PCWrite}); end
      n_cmp++; if (PC !== exp_pc) begin n_err++; $display("FAIL wait_pc[%0d]: got %0d want %0d", i, PC, exp_pc); end
      next_cycle();
    end
    mem_ready = 1'b1;
    #1;
    n_cmp++; if ({IRWrite, PCWrite} !== 2'b11) begin n_err++; $display("FAIL wait_ready: got %b want 11", {IRWrite, PCWrite}); end
    next_cycle();
    exp_pc = exp_pc + 32'd4;
    n_cmp++; if (PC !== exp_pc) begin n_err++; $display("FAIL wait_pc_once: got %0d want %0d", PC, exp_pc); end
    n_cmp++; if (fsm_state !== ST_DECODE) begin n_err++; $display("FAIL wait_decode: got %0d want %0d", fsm_state, ST_DECODE); end
    next_cycle();
    next_cycle();
    next_cycle();
    exp_instret = exp_instret + 32'd1;
    n_cmp++; if (instret !== exp_instret) begin n_err++; $display("FAIL wait_instret: got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_alu_decode();
    for (int i = 0; i < 8; i++) begin
      do_fetch(vec_instr[i], exp_pc + 32'd4);
      next_cycle();
      n_cmp++; if (fsm_state !== vec_state[i]) begin n_err++; $display("FAIL alu_state[%0d]: got %0d want %0d", i, fsm_state, vec_state[i]); end
      n_cmp++; if (ALUControl !== vec_ctrl[i]) begin n_err++; $display("FAIL alu_ctrl[%0d]: got %b want %b", i, ALUControl, vec_ctrl[i]); end
      n_cmp++; if ({ALUSrcA, ALUSrcB} !== {2'b10, vec_srcb[i]}) begin n_err++; $display("FAIL alu_src[%0d]: got %b want %b", i, {ALUSrcA, ALUSrcB}, {2'b10, vec_srcb[i]}); end
      next_cycle();
      n_cmp++; if (RegWrite !== 1'b1) begin n_err++; $display("FAIL alu_wb[%0d]: got %b want 1", i, RegWrite); end
      next_cycle();
      exp_instret = exp_instret + 32'd1;
      n_cmp++; if (instret !== exp_instret) begin n_err++; $display("FAIL alu_instret[%0d]: got %0d want %0d", i, instret, exp_instret); end
      n_cmp++; if (PC !== exp_pc) begin n_err++; $display("FAIL alu_pc[%0d]: got %0d want %0d", i, PC, exp_pc); end
    end
  endtask

  task automatic test_load_store();
    do_fetch(32'h0000A103, exp_pc + 32'd4);
    next_cycle();
    n_cmp++; if ({fsm_state, ALUSrcA, ALUSrcB, ImmSrc} !== {ST_MEMADR, 6'b10_01_00}) begin n_err++; $display("FAIL lw_memadr: got %b want %b", {fsm_state, ALUSrcA, ALUSrcB, ImmSrc}, {ST_MEMADR, 6'b10_01_00}); end
    mem_ready = 1'b0;
    next_cycle();
    n_cmp++; if ({fsm_state, mem_req, AddrSrc, RegWrite} !== {ST_MEMREAD, 3'b110}) begin n_err++; $display("FAIL lw_memread: got %b want %b", {fsm_state, mem_req, AddrSrc, RegWrite}, {ST_MEMREAD, 3'b110}); end
    next_cycle();
    mem_ready = 1'b1;
    next_cycle();
    n_cmp++; if ({fsm_state, RegWrite, ResultSrc} !== {ST_MEMWB, 3'b1_01}) begin n_err++; $display("FAIL lw_memwb: got %b want %b", {fsm_state, RegWrite, ResultSrc}, {ST_MEMWB, 3'b101}); end
    next_cycle();
    exp_instret = exp_instret + 32'd1;
    n_cmp++; if (instret !== exp_instret) begin n_err++; $display("FAIL lw_instret: got %0d want %0d", instret, exp_instret); end

    do_fetch(32'h0020A023, exp_pc + 32'd4);
    next_cycle();
    n_cmp++; if (ImmSrc !== 2'b01) begin n_err++; $display("FAIL sw_immsrc: got %b want 01", ImmSrc); end
    mem_ready = 1'b0;
    next_cycle();
    n_cmp++; if ({fsm_state, mem_req, AddrSrc, MemWrite} !== {ST_MEMWRITE, 3'b110}) begin n_err++; $display("FAIL sw_wait: got %b want %b", {fsm_state, mem_req, AddrSrc, MemWrite}, {ST_MEMWRITE, 3'b110}); end
    mem_ready = 1'b1;
    #1;
    n_cmp++; if (MemWrite !== 1'b1) begin n_err++; $display("FAIL sw_memwrite: got %b want 1", MemWrite); end
    next_cycle();
    exp_instret = exp_instret + 32'd1;
    n_cmp++; if ({fsm_state, instret} !== {ST_FETCH, exp_instret}) begin n_err++; $display("FAIL sw_done: got %0d/%0d want %0d/%0d", fsm_state, instret, ST_FETCH, exp_instret); end
  endtask

  task automatic test_beq();
    do_fetch(32'h00208463, exp_pc + 32'd4);
    next_cycle();
    Zero = 1'b1; ResultWire = 32'h3000;
    #1;
    n_cmp++; if ({fsm_state, PCWrite, ALUControl, ALUSrcA, ALUSrcB} !== {ST_BEQ, 1'b1, 3'b001, 4'b1000}) begin n_err++; $display("FAIL beq_taken: got %b want %b", {fsm_state, PCWrite, ALUControl, ALUSrcA, ALUSrcB}, {ST_BEQ, 8'b1_001_1000}); end
    next_cycle();
    exp_pc = 32'h3000;
    exp_instret = exp_instret + 32'd1;
    n_cmp++; if ({PC, instret} !== {exp_pc, exp_instret}) begin n_err++; $display("FAIL beq_taken_pc: got %h/%0d want %h/%0d", PC, instret, exp_pc, exp_instret); end
    do_fetch(32'h00208463, exp_pc + 32'd4);
    next_cycle();
    Zero = 1'b0; ResultWire = 32'h5000;
    #1;
    n_cmp++; if (PCWrite !== 1'b0) begin n_err++; $display("FAIL beq_not_taken: got %b want 0", PCWrite); end
    next_cycle();
    exp_instret = exp_instret + 32'd1;
    n_cmp++; if ({PC, instret} !== {exp_pc, exp_instret}) begin n_err++; $display("FAIL beq_nt_pc: got %h/%0d want %h/%0d", PC, instret, exp_pc, exp_instret); end
  endtask

  task automatic test_jal();
    do_fetch(32'h0080006F, exp_pc + 32'd4);
    next_cycle();
    ResultWire = 32'h4000;
    #1;
    n_cmp++; if ({fsm_state, PCWrite, ALUSrcA, ALUSrcB, ALUControl} !== {ST_JAL, 1'b1, 7'b01_10_000}) begin n_err++; $display("FAIL jal_state: got %b want %b", {fsm_state, PCWrite, ALUSrcA, ALUSrcB, ALUControl}, {ST_JAL, 8'b1_01_10_000}); end
    next_cycle();
    exp_pc = 32'h4000;
    n_cmp++; if ({fsm_state, RegWrite, PC} !== {ST_ALUWB, 1'b1, exp_pc}) begin n_err++; $display("FAIL jal_link: got %0d/%b/%h want %0d/1/%h", fsm_state, RegWrite, PC, ST_ALUWB, exp_pc); end
    next_cycle();
    exp_instret = exp_instret + 32'd1;
    n_cmp++; if (instret !== exp_instret) begin n_err++; $display("FAIL jal_instret: got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_reset_mid_write();
    do_fetch(32'h0020A023, exp_pc + 32'd4);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    #1;
    n_cmp++; if ({fsm_state, MemWrite, mem_req} !== {ST_MEMWRITE, 2'b00}) begin n_err++; $display("FAIL rstw_memwrite: got %b want %b", {fsm_state, MemWrite, mem_req}, {ST_MEMWRITE, 2'b00}); end
    next_cycle();
    n_cmp++; if ({fsm_state, PC, instret} !== {ST_FETCH, 32'd9600, 32'd0}) begin n_err++; $display("FAIL rstw_after: got %0d/%0d/%0d want 0/9600/0", fsm_state, PC, instret); end
    reset = 1'b0;
    exp_pc = 32'd9600;
    exp_instret = 32'd0;
  endtask

  task automatic test_illegal_opcode();
    do_fetch(32'h0000007F, exp_pc + 32'd4);
    ResultWire = 32'hDEAD0000;
    next_cycle();
    n_cmp++; if ({fsm_state, fault, instret} !== {ST_FAULT, 1'b1, exp_instret}) begin n_err++; $display("FAIL illop_fault: got %0d/%b/%0d want %0d/1/%0d", fsm_state, fault, instret, ST_FAULT, exp_instret); end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      n_cmp++; if ({PCWrite, IRWrite, RegWrite, MemWrite, mem_req, PC} !== {5'b0, exp_pc}) begin n_err++; $display("FAIL illop_frozen[%0d]: got %b/%0d want 00000/%0d", i, {PCWrite, IRWrite, RegWrite, MemWrite, mem_req}, PC, exp_pc); end
    end
    apply_reset();
  endtask

  task automatic test_illegal_funct3();
    do_fetch(32'h002091B3, exp_pc + 32'd4);
    next_cycle();
    next_cycle();
    n_cmp++; if ({fsm_state, fault, RegWrite} !== {ST_FAULT, 2'b10}) begin n_err++; $display("FAIL illf3_fault: got %b want %b", {fsm_state, fault, RegWrite}, {ST_FAULT, 2'b10}); end
    apply_reset();
  endtask

  task automatic test_timeout();
    int k;
    ResultWire = 32'h7777;
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 15; i++) begin
      n_cmp++; if ({fault, mem_req, IRWrite} !== 3'b010) begin n_err++; $display("FAIL tmo_wait[%0d]: got %b want 010", i, {fault, mem_req, IRWrite}); end
      next_cycle();
    end
    mem_ready = 1'b1;
    #1;
    n_cmp++; if ({IRWrite, PCWrite} !== 2'b00) begin n_err++; $display("FAIL tmo_late_ready: got %b want 00", {IRWrite, PCWrite}); end
    k = 0;
    while (fault !== 1'b1 && k < 4) begin
      next_cycle();
      k++;
    end
    n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL tmo_fault: got %b want 1 within 4 cycles", fault); end
    for (int i = 0; i < 20; i++) begin
      n_cmp++; if ({PCWrite, IRWrite, RegWrite, MemWrite, mem_req, fault, PC} !== {6'b000001, exp_pc}) begin n_err++; $display("FAIL tmo_absorb[%0d]: got %b/%0d want 000001/%0d", i, {PCWrite, IRWrite, RegWrite, MemWrite, mem_req, fault}, PC, exp_pc); end
      next_cycle();
    end
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_fetch_wait();
    test_alu_decode();
    test_load_store();
    test_beq();
    test_jal();
    test_reset_mid_write();
    test_illegal_opcode();
    test_illegal_funct3();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
